// File: rtl/race_gear_pkg.sv
// race_gear_pkg: types and default geometry shared by the race game video blocks.
package race_gear_pkg;

  // Visible raster and car sprite defaults.
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int CAR_W_DEF    = 80;
  localparam int CAR_H_DEF    = 121;

  // Coordinates widened by one bit so that position + sprite size never wraps.
  typedef logic [10:0] coord_t;

  // Collision monitor states.
  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_HIT   = 2'd1,
    ST_GRACE = 2'd2,
    ST_OVER  = 2'd3
  } monitor_state_t;

endpackage

// File: rtl/car_box_hit.sv
// car_box_hit: combinational test of whether the scan position lies inside a
// car sprite's rectangle. Bounds are summed at 11 bits so a car parked low on
// the screen cannot wrap its bottom edge back into view.
module car_box_hit
  import race_gear_pkg::*;
#(
  parameter int CAR_W = CAR_W_DEF,
  parameter int CAR_H = CAR_H_DEF
) (
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic       in_box
);

  localparam coord_t CAR_W_C = coord_t'(CAR_W);
  localparam coord_t CAR_H_C = coord_t'(CAR_H);

  coord_t left_s;
  coord_t right_s;
  coord_t top_s;
  coord_t bottom_s;
  coord_t h_s;
  coord_t v_s;

  assign left_s   = {1'b0, pos_x};
  assign top_s    = {1'b0, pos_y};
  assign right_s  = left_s + CAR_W_C;
  assign bottom_s = top_s + CAR_H_C;
  assign h_s      = {1'b0, hcount};
  assign v_s      = {1'b0, vcount};

  assign in_box = (h_s >= left_s) && (h_s < right_s) &&
                  (v_s >= top_s)  && (v_s < bottom_s);

endmodule

// File: rtl/collision_monitor.sv
// collision_monitor: per-frame enemy/player contact detection, lives, post-hit
// freeze and grace period, and game-over.
// Optional feature: define COLLISION_BBOX_EN to also treat an overlap of the two
// car rectangles at the frame tick as a hit (catches transparent-edge contacts).
module collision_monitor
  import race_gear_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int CAR_W        = CAR_W_DEF,
  parameter int CAR_H        = CAR_H_DEF,
  parameter int LIVES        = 3,
  parameter int HIT_FRAMES   = 60,
  parameter int GRACE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [9:0] enemy_pos_x,
  input  logic [9:0] enemy_pos_y,
  input  logic [2:0] enemy_data,
  input  logic [9:0] player_pos_x,
  input  logic [9:0] player_pos_y,
  input  logic [2:0] player_data,
  input  logic       restart,
  output logic       collision,
  output logic       hit_pulse,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [9:0] H_ACT_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C = 10'(V_ACTIVE);
  localparam logic [1:0] LIVES_C = 2'(LIVES);
  localparam logic [7:0] HIT_C   = 8'(HIT_FRAMES);
  localparam logic [7:0] GRACE_C = 8'(GRACE_FRAMES);

  logic           enemy_in_box_s;
  logic           player_in_box_s;
  logic           pixel_hit_s;
  logic           tick_s;
  logic           frame_hit_s;
  logic [9:0]     vcount_r;
  logic           overlap_r;
  monitor_state_t state_r;
  logic [7:0]     frame_cnt_r;
  logic           collision_r;
  logic           hit_pulse_r;
  logic [1:0]     lives_r;
  logic           game_over_r;

  car_box_hit #(.CAR_W(CAR_W), .CAR_H(CAR_H)) u_enemy_box (
    .pos_x  (enemy_pos_x),
    .pos_y  (enemy_pos_y),
    .hcount (hcount),
    .vcount (vcount),
    .in_box (enemy_in_box_s)
  );

  car_box_hit #(.CAR_W(CAR_W), .CAR_H(CAR_H)) u_player_box (
    .pos_x  (player_pos_x),
    .pos_y  (player_pos_y),
    .hcount (hcount),
    .vcount (vcount),
    .in_box (player_in_box_s)
  );

  // Both cars draw an opaque pixel at the same visible location.
  assign pixel_hit_s = (hcount < H_ACT_C) && (vcount < V_ACT_C) &&
                       enemy_in_box_s && player_in_box_s &&
                       (|enemy_data) && (|player_data);

  // First cycle of the vertical blanking line.
  assign tick_s = (vcount == V_ACT_C) && (vcount_r != V_ACT_C);

`ifdef COLLISION_BBOX_EN
  localparam coord_t CAR_W_C = coord_t'(CAR_W);
  localparam coord_t CAR_H_C = coord_t'(CAR_H);
  localparam coord_t H_ACT_W = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_W = coord_t'(V_ACTIVE);

  coord_t ex_s;
  coord_t ey_s;
  coord_t px_s;
  coord_t py_s;
  logic   bbox_hit_s;

  assign ex_s = {1'b0, enemy_pos_x};
  assign ey_s = {1'b0, enemy_pos_y};
  assign px_s = {1'b0, player_pos_x};
  assign py_s = {1'b0, player_pos_y};

  // Rectangle overlap; both tops on screen keeps the shared extent visible.
  assign bbox_hit_s = (ex_s < H_ACT_W) && (px_s < H_ACT_W) &&
                      (ey_s < V_ACT_W) && (py_s < V_ACT_W) &&
                      (ex_s < (px_s + CAR_W_C)) && (px_s < (ex_s + CAR_W_C)) &&
                      (ey_s < (py_s + CAR_H_C)) && (py_s < (ey_s + CAR_H_C));

  assign frame_hit_s = overlap_r | bbox_hit_s;
`else
  assign frame_hit_s = overlap_r;
`endif

  // Previous scan line, used to find the blanking edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcount_r <= 10'd0;
    end else begin
      vcount_r <= vcount;
    end
  end

  // Sticky per-frame pixel contact flag, emptied at every tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overlap_r <= 1'b0;
    end else if (restart || tick_s) begin
      overlap_r <= 1'b0;
    end else if (pixel_hit_s) begin
      overlap_r <= 1'b1;
    end else begin
      overlap_r <= overlap_r;
    end
  end

  // Hit / grace / game-over sequencing with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_ARMED;
      lives_r     <= LIVES_C;
      frame_cnt_r <= 8'd0;
      collision_r <= 1'b0;
      hit_pulse_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      hit_pulse_r <= 1'b0;
      if (restart) begin
        state_r     <= ST_ARMED;
        lives_r     <= LIVES_C;
        frame_cnt_r <= 8'd0;
        collision_r <= 1'b0;
        game_over_r <= 1'b0;
      end else if (tick_s) begin
        case (state_r)
          ST_ARMED: begin
            if (frame_hit_s) begin
              hit_pulse_r <= 1'b1;
              collision_r <= 1'b1;
              if (lives_r > 2'd1) begin
                lives_r     <= lives_r - 2'd1;
                frame_cnt_r <= HIT_C;
                state_r     <= ST_HIT;
              end else begin
                lives_r     <= 2'd0;
                game_over_r <= 1'b1;
                state_r     <= ST_OVER;
              end
            end else begin
              state_r <= ST_ARMED;
            end
          end
          ST_HIT: begin
            if (frame_cnt_r <= 8'd1) begin
              frame_cnt_r <= GRACE_C;
              collision_r <= 1'b0;
              state_r     <= ST_GRACE;
            end else begin
              frame_cnt_r <= frame_cnt_r - 8'd1;
            end
          end
          ST_GRACE: begin
            if (frame_cnt_r <= 8'd1) begin
              frame_cnt_r <= 8'd0;
              state_r     <= ST_ARMED;
            end else begin
              frame_cnt_r <= frame_cnt_r - 8'd1;
            end
          end
          ST_OVER: begin
            collision_r <= 1'b1;
            game_over_r <= 1'b1;
          end
          default: begin
            state_r     <= ST_ARMED;
            frame_cnt_r <= 8'd0;
            collision_r <= 1'b0;
            game_over_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign collision = collision_r;
  assign hit_pulse = hit_pulse_r;
  assign lives     = lives_r;
  assign game_over = game_over_r;

endmodule

// File: tb/tb_collision_monitor.sv
// tb_collision_monitor: directed frames on a compressed raster (one probe pixel,
// then the blanking line). Expected hits and output snapshots go into queues;
// a negedge monitor pops and compares them against the DUT.
module tb_collision_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] enemy_pos_x;
  logic [9:0] enemy_pos_y;
  logic [2:0] enemy_data;
  logic [9:0] player_pos_x;
  logic [9:0] player_pos_y;
  logic [2:0] player_data;
  logic       restart;
  logic       collision;
  logic       hit_pulse;
  logic [1:0] lives;
  logic       game_over;

  typedef struct {
    string      name;
    int         tick;
    logic [1:0] lives;
    logic       coll;
    logic       go;
  } exp_t;

  exp_t hit_q[$];
  exp_t snap_q[$];
  int   tick_cnt = 0;
  int   n_pass   = 0;
  int   n_total  = 0;
  logic hit_prev = 1'b0;

  collision_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .enemy_pos_x  (enemy_pos_x),
    .enemy_pos_y  (enemy_pos_y),
    .enemy_data   (enemy_data),
    .player_pos_x (player_pos_x),
    .player_pos_y (player_pos_y),
    .player_data  (player_data),
    .restart      (restart),
    .collision    (collision),
    .hit_pulse    (hit_pulse),
    .lives        (lives),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input bit ok, input string act, input string req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", nm, act, req);
  endtask

  // Scoreboard monitor: hit events and snapshots.
  always @(negedge clk) begin
    exp_t e;
    if (hit_pulse === 1'b1) begin
      check("hit_width", hit_prev == 1'b0, "pulse longer than 1 cycle", "1 cycle");
      if (hit_q.size() == 0) begin
        check("unexpected_hit", 1'b0, $sformatf("hit at tick %0d", tick_cnt), "no hit");
      end else begin
        e = hit_q.pop_front();
        check(e.name,
              (tick_cnt == e.tick) && (lives === e.lives) && (collision === e.coll) && (game_over === e.go),
              $sformatf("tick=%0d lives=%0d coll=%0b over=%0b", tick_cnt, lives, collision, game_over),
              $sformatf("tick=%0d lives=%0d coll=%0b over=%0b", e.tick, e.lives, e.coll, e.go));
      end
    end
    hit_prev <= hit_pulse;
    if (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      check(e.name,
            (lives === e.lives) && (collision === e.coll) && (game_over === e.go),
            $sformatf("lives=%0d coll=%0b over=%0b", lives, collision, game_over),
            $sformatf("lives=%0d coll=%0b over=%0b", e.lives, e.coll, e.go));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_snap(input string nm, input logic [1:0] l, input logic c, input logic g);
    exp_t e;
    e.name = nm; e.tick = 0; e.lives = l; e.coll = c; e.go = g;
    snap_q.push_back(e);
  endtask

  // Expect a hit on the next tick the bench issues.
  task automatic expect_hit(input string nm, input logic [1:0] l, input logic g);
    exp_t e;
    e.name = nm; e.tick = tick_cnt + 1; e.lives = l; e.coll = 1'b1; e.go = g;
    hit_q.push_back(e);
  endtask

  task automatic set_cars(input logic [9:0] ex, input logic [9:0] ey, input logic [9:0] px,
                          input logic [9:0] py, input logic [2:0] ed, input logic [2:0] pd);
    enemy_pos_x = ex; enemy_pos_y = ey; player_pos_x = px; player_pos_y = py;
    enemy_data = ed; player_data = pd;
  endtask

  // One compressed frame: probe pixel, tick (optionally with restart), blanking.
  task automatic run_frame(input logic [9:0] h, input logic [9:0] v, input bit rs, input bit snap,
                           input string nm, input logic [1:0] l, input logic c, input logic g);
    step(); hcount = h; vcount = v;
    step(); tick_cnt++; hcount = 10'd0; vcount = 10'd480; restart = rs;
    step(); restart = 1'b0; if (snap) expect_snap(nm, l, c, g);
    step(); vcount = 10'd490;
  endtask

  task automatic pulse_restart(input string nm);
    step(); restart = 1'b1;
    step(); restart = 1'b0; expect_snap(nm, 2'd3, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; restart = 1'b0; hcount = 10'd0; vcount = 10'd500;
    set_cars(10'd200, 10'd100, 10'd200, 10'd150, 3'b101, 3'b101);
    #1 reset = 1'b0;
    step(); step(); expect_snap("reset_state", 2'd3, 1'b0, 1'b0);
    step(); reset = 1'b1;

    // Overlap and first hit.
    expect_hit("first_hit", 2'd2, 1'b0);
    run_frame(10'd240, 10'd180, 1'b0, 1'b1, "first_hit_state", 2'd2, 1'b1, 1'b0);

    // Freeze for 60 ticks, grace for 120 more, second hit on tick 181.
    for (int r = 1; r <= 180; r++)
      run_frame(10'd240, 10'd180, 1'b0, (r == 59) || (r == 60) || (r == 180),
                $sformatf("grace_r%0d", r), 2'd2, (r < 60), 1'b0);
    expect_hit("second_hit", 2'd1, 1'b0);
    run_frame(10'd240, 10'd180, 1'b0, 1'b1, "second_hit_state", 2'd1, 1'b1, 1'b0);

    // Third hit ends the game.
    for (int r = 1; r <= 180; r++)
      run_frame(10'd240, 10'd180, 1'b0, (r == 59) || (r == 60) || (r == 180),
                $sformatf("grace2_r%0d", r), 2'd1, (r < 60), 1'b0);
    expect_hit("final_hit", 2'd0, 1'b1);
    run_frame(10'd240, 10'd180, 1'b0, 1'b1, "game_over_state", 2'd0, 1'b1, 1'b1);
    run_frame(10'd240, 10'd180, 1'b0, 1'b0, "", 2'd0, 1'b1, 1'b1);
    run_frame(10'd240, 10'd180, 1'b0, 1'b1, "game_over_held", 2'd0, 1'b1, 1'b1);

    // Restart on a tick: leaves OVER, and in ARMED it beats a pending overlap.
    run_frame(10'd240, 10'd180, 1'b1, 1'b1, "restart_from_over", 2'd3, 1'b0, 1'b0);
    run_frame(10'd240, 10'd180, 1'b1, 1'b1, "restart_wins_tick", 2'd3, 1'b0, 1'b0);

    // Mid-frame restart discards overlap already collected.
    step(); hcount = 10'd240; vcount = 10'd180;
    step(); hcount = 10'd700; vcount = 10'd10; restart = 1'b1;
    step(); restart = 1'b0;
    set_cars(10'd200, 10'd100, 10'd400, 10'd300, 3'b101, 3'b101);
    run_frame(10'd700, 10'd10, 1'b0, 1'b1, "restart_clears_overlap", 2'd3, 1'b0, 1'b0);

    // Transparent player pixel over the overlap region.
    set_cars(10'd200, 10'd100, 10'd200, 10'd150, 3'b101, 3'b000);
`ifdef COLLISION_BBOX_EN
    expect_hit("transparent_bbox_hit", 2'd2, 1'b0);
    run_frame(10'd240, 10'd180, 1'b0, 1'b1, "transparent_state", 2'd2, 1'b1, 1'b0);
`else
    run_frame(10'd240, 10'd180, 1'b0, 1'b1, "transparent_no_hit", 2'd3, 1'b0, 1'b0);
`endif
    pulse_restart("restart_after_transparent");

    // Both in box but beyond the visible width.
    set_cars(10'd600, 10'd300, 10'd600, 10'd300, 3'b101, 3'b101);
`ifdef COLLISION_BBOX_EN
    expect_hit("offscreen_bbox_hit", 2'd2, 1'b0);
    run_frame(10'd650, 10'd350, 1'b0, 1'b1, "offscreen_state", 2'd2, 1'b1, 1'b0);
`else
    run_frame(10'd650, 10'd350, 1'b0, 1'b1, "offscreen_no_hit", 2'd3, 1'b0, 1'b0);
`endif
    pulse_restart("restart_after_offscreen");

    // Enemy parked below the screen.
    set_cars(10'd200, 10'd620, 10'd200, 10'd359, 3'b101, 3'b101);
    run_frame(10'd240, 10'd400, 1'b0, 1'b1, "parked_mid", 2'd3, 1'b0, 1'b0);
    run_frame(10'd240, 10'd479, 1'b0, 1'b1, "parked_bottom", 2'd3, 1'b0, 1'b0);

    // Right-edge boundary: adjacent boxes do not touch, one column overlap does.
    set_cars(10'd200, 10'd100, 10'd280, 10'd100, 3'b101, 3'b101);
    run_frame(10'd280, 10'd150, 1'b0, 1'b1, "edge_x280", 2'd3, 1'b0, 1'b0);
    run_frame(10'd279, 10'd150, 1'b0, 1'b1, "edge_x279", 2'd3, 1'b0, 1'b0);
    set_cars(10'd200, 10'd100, 10'd279, 10'd100, 3'b101, 3'b101);
    expect_hit("edge_touch_hit", 2'd2, 1'b0);
    run_frame(10'd279, 10'd150, 1'b0, 1'b1, "edge_touch_state", 2'd2, 1'b1, 1'b0);
    pulse_restart("restart_after_edge");

    // Reset asserted 30 frames into HIT, then a fresh hit.
    set_cars(10'd200, 10'd100, 10'd200, 10'd150, 3'b101, 3'b101);
    expect_hit("pre_reset_hit", 2'd2, 1'b0);
    run_frame(10'd240, 10'd180, 1'b0, 1'b0, "", 2'd2, 1'b1, 1'b0);
    for (int r = 1; r <= 29; r++)
      run_frame(10'd240, 10'd180, 1'b0, 1'b0, "", 2'd2, 1'b1, 1'b0);
    step(); hcount = 10'd240; vcount = 10'd180; reset = 1'b0;
    expect_snap("reset_mid_hit", 2'd3, 1'b0, 1'b0);
    step(); step(); reset = 1'b1;
    expect_hit("post_reset_hit", 2'd2, 1'b0);
    run_frame(10'd240, 10'd180, 1'b0, 1'b1, "post_reset_state", 2'd2, 1'b1, 1'b0);

    repeat (4) step();
    check("hit_queue_drained", hit_q.size() == 0, $sformatf("%0d pending", hit_q.size()), "0 pending");
    check("snap_queue_drained", snap_q.size() == 0, $sformatf("%0d pending", snap_q.size()), "0 pending");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
